bram_stream_reader: RTL



---
 rtl/bram_stream_reader.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/bram_stream_reader.sv
// ---------------------------------------------------------------------------
// bram_stream_reader
//
// Reads a programmed span of the capture buffer's 32-bit port B and presents
// the words as an AXI4-Stream master. The BRAM read latency is absorbed by a
// small credit-controlled FIFO. With tready held high, one beat is sent every
// clock.
//
// Optional feature macro: BRAM_READER_TLAST_EN (adds m_axis_tlast).
//
// Ports
//   clk            system clock
//   rstn           synchronous active-low reset
//   start          one-cycle command pulse (honoured only when idle)
//   base           first port-B address, sampled with start
//   len            number of words, 0..2^ADDR_W, sampled with start
//   busy           transfer in progress (from accepted start until done)
//   done           one-cycle end-of-transfer pulse
//   bram_addr      port-B address (addrb)
//   bram_en        port-B read enable (enb)
//   bram_dout      port-B read data (doutb)
//   m_axis_tdata   stream data
//   m_axis_tvalid  stream valid
//   m_axis_tready  stream ready
//   m_axis_tlast   final beat marker (BRAM_READER_TLAST_EN only)
// ---------------------------------------------------------------------------
module bram_stream_reader #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_en,
    input  logic [DATA_W-1:0] bram_dout,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready
`ifdef BRAM_READER_TLAST_EN
    ,
    output logic              m_axis_tlast
`endif
);

    localparam int FIFO_DEPTH = READ_LAT + 3;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] nxt_addr;   // address of the next read to issue
    logic [ADDR_W:0]   rem;        // reads still to issue
    logic [READ_LAT-1:0] vld_p;    // tracks issued reads through the BRAM
    logic [CNT_W-1:0]  inflight;   // issued reads not yet in the FIFO
    logic [CNT_W-1:0]  count;      // FIFO occupancy
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];

    logic              pop;
    logic              push;
    logic              credit;
    logic              issue_start;
    logic              issue_run;
    logic              issue;
    logic [CNT_W-1:0]  occ_after_pop;
    logic [CNT_W:0]    credit_sum;

    assign m_axis_tvalid = (count != '0);
    // The head register is not reset, so gate it to keep tdata at zero when idle.
    assign m_axis_tdata  = m_axis_tvalid ? mem[rd_ptr] : '0;

    assign pop  = m_axis_tvalid & m_axis_tready;
    assign push = vld_p[READ_LAT-1];

    // A read may only be issued if the FIFO can hold it even when every read
    // already in flight lands first; the pop this cycle frees a slot early.
    assign occ_after_pop = count - CNT_W'(pop);
    assign credit_sum    = {1'b0, occ_after_pop} + {1'b0, inflight};
    assign credit        = (credit_sum < (CNT_W + 1)'(FIFO_DEPTH));

    // The first read goes out on the same edge that accepts start; the FIFO
    // is always empty in IDLE so no credit check is needed there.
    assign issue_start = (state == IDLE) && start && (len != '0);
    assign issue_run   = (state == RUN) && (rem != '0) && credit;
    assign issue       = issue_start | issue_run;

    assign busy = (state != IDLE);
    assign done = (state == FIN);

    // Next-state logic. An empty transfer passes through DRAIN (which exits at
    // once) so done keeps the same one-cycle spacing after the command.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len != '0) ? RUN : DRAIN;
                end
            end
            RUN: begin
                if (rem == '0) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if ((inflight == '0) && (occ_after_pop == '0)) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Stage p0: FSM, address generation and read issue
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            bram_en   <= 1'b0;
            bram_addr <= '0;
            nxt_addr  <= '0;
            rem       <= '0;
        end else begin
            state   <= state_nxt;
            bram_en <= issue;
            if (issue_start) begin
                bram_addr <= base;
                nxt_addr  <= base + 1'b1;
                rem       <= len - 1'b1;
            end else if (issue_run) begin
                bram_addr <= nxt_addr;
                nxt_addr  <= nxt_addr + 1'b1;
                rem       <= rem - 1'b1;
            end
        end
    end

    // Stage p1..pN: valid follows the read through the BRAM latency
    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_p    <= '0;
            inflight <= '0;
        end else begin
            vld_p[0] <= bram_en;
            for (int i = 1; i < READ_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
            inflight <= inflight + CNT_W'(issue) - CNT_W'(push);
        end
    end

    // Stage FIFO: capture landed words, present the head to the stream
    always_ff @(posedge clk) begin
        if (!rstn) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bram_dout;
        end
    end

`ifdef BRAM_READER_TLAST_EN
    // Beats still to be sent; the head word is the last one when this is 1.
    logic [ADDR_W:0] beats_left;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            beats_left <= '0;
        end else if ((state == IDLE) && start) begin
            beats_left <= len;
        end else if (pop) begin
            beats_left <= beats_left - 1'b1;
        end
    end

    assign m_axis_tlast = m_axis_tvalid && (beats_left == (ADDR_W + 1)'(1));
`endif

endmodule
